// File: rtl/vga_timing_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_controller: VGA raster timing plus tear-free buffer swap        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_timing_controller #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       front_buf,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       line_end
);

  localparam logic [15:0] c_H_VIS        = 16'(H_VISIBLE);
  localparam logic [15:0] c_H_SYNC_START = 16'(H_VISIBLE + H_FP);
  localparam logic [15:0] c_H_SYNC_END   = 16'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [15:0] c_H_LAST       = 16'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] c_V_VIS        = 16'(V_VISIBLE);
  localparam logic [15:0] c_V_SYNC_START = 16'(V_VISIBLE + V_FP);
  localparam logic [15:0] c_V_SYNC_END   = 16'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [15:0] c_V_LAST       = 16'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } swap_state_t;

  logic [15:0] r_h_cnt;
  logic [15:0] r_v_cnt;
  logic        r_swap_ack;
  logic        r_front_buf;
  swap_state_t r_state;
  swap_state_t w_state_next;

  logic w_line_end;
  logic w_v_last;
  logic w_frame_last;
  logic w_req_new;
  logic w_do_swap;
  logic w_h_vis;
  logic w_v_vis;
  logic w_h_sync;
  logic w_v_sync;

  assign w_line_end   = (r_h_cnt == c_H_LAST);
  assign w_v_last     = (r_v_cnt == c_V_LAST);
  assign w_frame_last = w_line_end & w_v_last;

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_h_cnt <= 16'd0;
      r_v_cnt <= 16'd0;
    end else if (w_line_end) begin
      r_h_cnt <= 16'd0;
      r_v_cnt <= w_v_last ? 16'd0 : r_v_cnt + 16'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 16'd1;
    end
  end

  // The ack cycle masks swap_req so a held request is only re-armed a cycle later.
  assign w_req_new = swap_req & ~r_swap_ack;

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_do_swap    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_new) begin
          if (w_frame_last) begin
            w_do_swap = 1'b1;
          end else begin
            w_state_next = S_PENDING;
          end
        end
      end
      S_PENDING: begin
        if (w_frame_last) begin
          w_do_swap    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      r_swap_ack  <= 1'b0;
      r_front_buf <= 1'b0;
    end else begin
      r_swap_ack <= w_do_swap;
      if (w_do_swap) begin
        r_front_buf <= ~r_front_buf;
      end
    end
  end

  assign w_h_vis  = (r_h_cnt < c_H_VIS);
  assign w_v_vis  = (r_v_cnt < c_V_VIS);
  assign w_h_sync = (r_h_cnt >= c_H_SYNC_START) && (r_h_cnt < c_H_SYNC_END);
  assign w_v_sync = (r_v_cnt >= c_V_SYNC_START) && (r_v_cnt < c_V_SYNC_END);

  assign hsync       = w_h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync       = w_v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign video_on    = w_h_vis & w_v_vis;
  assign x           = video_on ? r_h_cnt[9:0] : 10'd0;
  assign y           = video_on ? r_v_cnt[9:0] : 10'd0;
  assign line_end    = w_line_end;
  assign frame_start = (r_h_cnt == 16'd0) && (r_v_cnt == 16'd0);
  assign swap_ack    = r_swap_ack;
  assign front_buf   = r_front_buf;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_timing_controller: scoreboard bench on a shrunken raster            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_vga_timing_controller;

  localparam int HV = 20, HFP = 3, HS = 5, HBP = 4;
  localparam int VV = 10, VFP = 2, VS = 3, VBP = 4;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam bit SA = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       swap_req = 1'b0;
  logic       swap_ack, front_buf, hsync, vsync, video_on, frame_start, line_end;
  logic [9:0] x, y;

  always #20 clk = ~clk;

  vga_timing_controller #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_ACTIVE(SA)
  ) u_dut (
    .clk_25MHz(clk), .reset(reset), .swap_req(swap_req), .swap_ack(swap_ack),
    .front_buf(front_buf), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y), .frame_start(frame_start), .line_end(line_end)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference raster and swap behaviour
  int m_h = 0, m_v = 0;
  bit m_pend = 0, m_front = 0, m_ack = 0;

  task automatic model_edge();
    bit last, want;
    if (reset) begin
      m_h = 0; m_v = 0; m_pend = 0; m_front = 0; m_ack = 0;
    end else begin
      last   = (m_h == HT - 1) && (m_v == VT - 1);
      want   = m_pend || (swap_req && !m_ack);
      m_ack  = last && want;
      if (m_ack) m_front = !m_front;
      m_pend = want && !last;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end
  endtask

  function automatic logic [26:0] model_out();
    bit hs, vs, von;
    logic [9:0] mx, my;
    hs  = (m_h >= HV + HFP && m_h < HV + HFP + HS) ? SA : !SA;
    vs  = (m_v >= VV + VFP && m_v < VV + VFP + VS) ? SA : !SA;
    von = (m_h < HV) && (m_v < VV);
    mx  = von ? 10'(m_h) : 10'd0;
    my  = von ? 10'(m_v) : 10'd0;
    return {m_ack, m_front, hs, vs, von, mx, my,
            (m_h == 0 && m_v == 0), (m_h == HT - 1)};
  endfunction

  logic [26:0] sb_q[$];
  int idx = 0, first_le = -1;
  int c_fs = 0, c_hs = 0, c_vs = 0, c_von = 0, c_ack = 0;

  task automatic step();
    logic [26:0] exp_v, got_v;
    model_edge();
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    got_v = {swap_ack, front_buf, hsync, vsync, video_on, x, y, frame_start, line_end};
    check("cycle", 32'(got_v), 32'(exp_v));
    idx++;
    if (frame_start) c_fs++;
    if (hsync == SA) c_hs++;
    if (vsync == SA) c_vs++;
    if (video_on) c_von++;
    if (swap_ack) c_ack++;
    if (line_end && first_le < 0) first_le = idx;
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 2 * FRAME && !(m_h == h && m_v == v); i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (!swap_ack && n < FRAME + 2) begin
      step();
      n++;
    end
    check(tag, 32'(swap_ack), 32'd1);
  endtask

  int t_ack;

  initial begin
    #(40 * 50000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    do_reset();
    check("rst_state",
          32'({video_on, x, y, hsync, vsync, frame_start, line_end, swap_ack, front_buf}),
          32'({1'b1, 10'd0, 10'd0, !SA, !SA, 1'b1, 1'b0, 1'b0, 1'b0}));

    // Two clean frames: raster statistics
    idx = 0; first_le = -1; c_fs = 0; c_hs = 0; c_vs = 0; c_von = 0; c_ack = 0;
    repeat (2 * FRAME) step();
    check("first_line_end", 32'(first_le), 32'(HT - 1));
    check("frame_starts", 32'(c_fs), 32'd2);
    check("hsync_cycles", 32'(c_hs), 32'(2 * VT * HS));
    check("vsync_cycles", 32'(c_vs), 32'(2 * VS * HT));
    check("video_cycles", 32'(c_von), 32'(2 * HV * VV));
    check("no_spurious_ack", 32'(c_ack), 32'd0);

    // Mid-frame request held until ack
    run_to(5, 4);
    swap_req = 1'b1;
    c_ack = 0;
    wait_ack("A_ack");
    check("A_front", 32'(front_buf), 32'd1);
    check("A_ack_at_fs", 32'(frame_start), 32'd1);
    swap_req = 1'b0;
    repeat (FRAME + 5) step();
    check("A_ack_count", 32'(c_ack), 32'd1);
    check("A_front_hold", 32'(front_buf), 32'd1);

    // Request first seen on the last frame cycle, held past the ack
    do_reset();
    run_to(HT - 1, VT - 1);
    swap_req = 1'b1;
    c_ack = 0;
    step();
    check("B_ack_now", 32'(swap_ack), 32'd1);
    check("B_front1", 32'(front_buf), 32'd1);
    t_ack = idx;
    step();
    step();
    swap_req = 1'b0;
    wait_ack("B_ack2");
    check("B_ack2_period", 32'(idx - t_ack), 32'(FRAME));
    check("B_front0", 32'(front_buf), 32'd0);
    repeat (FRAME + 5) step();
    check("B_ack_count", 32'(c_ack), 32'd2);

    // Reset with a swap pending discards it
    do_reset();
    run_to(10, 6);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    run_to(12, 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("C_rst_pos", 32'({frame_start, x, y}), 32'({1'b1, 10'd0, 10'd0}));
    check("C_front", 32'(front_buf), 32'd0);
    c_ack = 0;
    repeat (FRAME + 5) step();
    check("C_no_ack", 32'(c_ack), 32'd0);
    check("C_front_hold", 32'(front_buf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
